// File: rtl/laundry_floor_panel_if.sv
// Bus between the floor panel and the laundry controller / floor buttons.
// The panel side uses the slave modport; the controller/bench side uses master.
interface laundry_floor_panel_if;
    logic [3:0] btn;
    logic [2:0] at_floor;
    logic [3:0] req_laundry;
    logic [3:0] send;
    logic       busy;
    logic       load_abort;
    logic [7:0] served_cnt;

    modport master (
        output btn, at_floor,
        input  req_laundry, send, busy, load_abort, served_cnt
    );

    modport slave (
        input  btn, at_floor,
        output req_laundry, send, busy, load_abort, served_cnt
    );
endinterface

// File: rtl/laundry_floor_panel.sv
// Floor-side request/load station: latches button presses into pending
// requests and strobes send[] at the floor where the cart dwells.
module laundry_floor_panel #(
    parameter int DWELL_CYCLES = 2,
    parameter int LOAD_CYCLES  = 4
) (
    input  logic clk,
    input  logic reset,
    laundry_floor_panel_if.slave bus
);
    localparam int MAX_CYCLES = (DWELL_CYCLES > LOAD_CYCLES) ? DWELL_CYCLES : LOAD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOAD, RELEASE} state_t;

    state_t           state_reg;
    logic [1:0]       fl_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       req_reg;
    logic [3:0]       send_reg;
    logic             abort_reg;
    logic [7:0]       served_reg;

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] edge_reg;
    logic [3:0] rise;
    logic [3:0] absorb_mask;
    logic [3:0] req_set;
    logic [3:0] fl_onehot;
    logic       at_fl;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            edge_reg  <= '0;
        end else begin
            sync1_reg <= bus.btn;
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg;
        end
    end

    // Per-floor edge detect; a press on the floor being served is swallowed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_floor
            assign rise[gi]        = sync2_reg[gi] & ~edge_reg[gi];
            assign absorb_mask[gi] = (state_reg != IDLE) && (fl_reg == 2'(gi));
            assign fl_onehot[gi]   = (fl_reg == 2'(gi));
        end
    endgenerate

    assign req_set = req_reg | (rise & ~absorb_mask);

    // In-transit codes (4-7) have bit 2 set and therefore never match fl_reg.
    assign at_fl = (bus.at_floor == {1'b0, fl_reg});

    // Serving FSM: dwell check, timed load strobe, then wait for the cart to leave.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            fl_reg     <= '0;
            cnt_reg    <= '0;
            req_reg    <= '0;
            send_reg   <= '0;
            abort_reg  <= 1'b0;
            served_reg <= '0;
        end else begin
            abort_reg <= 1'b0;
            req_reg   <= req_set;
            case (state_reg)
                IDLE: begin
                    if (!bus.at_floor[2] && req_reg[bus.at_floor[1:0]]) begin
                        fl_reg    <= bus.at_floor[1:0];
                        cnt_reg   <= '0;
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!at_fl) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == DWELL_LAST) begin
                        cnt_reg   <= '0;
                        send_reg  <= fl_onehot;
                        state_reg <= LOAD;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                LOAD: begin
                    if (!at_fl) begin
                        abort_reg <= 1'b1;
                        send_reg  <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == LOAD_LAST) begin
                        send_reg   <= '0;
                        req_reg    <= req_set & ~fl_onehot;
                        served_reg <= served_reg + 8'd1;
                        state_reg  <= RELEASE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!at_fl) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_laundry = req_reg;
    assign bus.send        = send_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.load_abort  = abort_reg;
    assign bus.served_cnt  = served_reg;
endmodule

// File: tb/tb_laundry_floor_panel.sv
// Directed bench for laundry_floor_panel with default parameters.
module tb_laundry_floor_panel;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    laundry_floor_panel_if bus ();

    laundry_floor_panel #(.DWELL_CYCLES(2), .LOAD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle button pulse, then wait until the request is latched.
    task automatic press(input logic [3:0] mask);
        bus.btn = mask;
        step();
        bus.btn = 4'b0000;
        step();
        step();
    endtask

    // Full service of floor f starting from IDLE with the cart away.
    task automatic do_load(input logic [1:0] f);
        press(4'b0001 << f);
        bus.at_floor = {1'b0, f};
        repeat (7) step();
        bus.at_floor = 3'd7;
        step();
    endtask

    initial begin
        reset        = 1'b0;
        bus.btn      = 4'b0000;
        bus.at_floor = 3'd7;

        // Reset held while buttons toggle
        bus.btn = 4'b1111;
        step();
        bus.btn = 4'b0101;
        step();
        bus.btn = 4'b0000;
        step();
        $display("reset: req=%b send=%b busy=%b", bus.req_laundry, bus.send, bus.busy);
        chk("rst_req",    32'(bus.req_laundry), 32'h0);
        chk("rst_send",   32'(bus.send),        32'h0);
        chk("rst_busy",   32'(bus.busy),        32'h0);
        chk("rst_abort",  32'(bus.load_abort),  32'h0);
        chk("rst_served", 32'(bus.served_cnt),  32'h0);

        reset = 1'b1;
        repeat (3) step();

        // Button latency: set on the third edge
        bus.btn = 4'b1001;
        step();
        bus.btn = 4'b0000;
        chk("btn_lat_k", 32'(bus.req_laundry), 32'h0);
        step();
        chk("btn_lat_k1", 32'(bus.req_laundry), 32'h0);
        step();
        $display("press 1001: req=%b", bus.req_laundry);
        chk("btn_lat_k2", 32'(bus.req_laundry), 32'h9);

        // Normal load at floor 0
        bus.at_floor = 3'd0;
        step();
        chk("f0_settle_busy", 32'(bus.busy), 32'h1);
        chk("f0_settle_send", 32'(bus.send), 32'h0);
        step();
        chk("f0_dwell_send", 32'(bus.send), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("f0_send_%0d", i), 32'(bus.send), 32'h1);
        end
        step();
        $display("load f0: req=%b served=%0d", bus.req_laundry, bus.served_cnt);
        chk("f0_end_send",   32'(bus.send),        32'h0);
        chk("f0_end_req",    32'(bus.req_laundry), 32'h8);
        chk("f0_end_served", 32'(bus.served_cnt),  32'h1);
        chk("f0_release",    32'(bus.busy),        32'h1);

        // Move to floor 3: RELEASE->IDLE, then serve
        bus.at_floor = 3'd3;
        step();
        chk("f3_idle", 32'(bus.busy), 32'h0);
        step();
        chk("f3_settle", 32'(bus.busy), 32'h1);
        step();
        chk("f3_dwell_send", 32'(bus.send), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("f3_send_%0d", i), 32'(bus.send), 32'h8);
        end
        step();
        $display("load f3: req=%b served=%0d", bus.req_laundry, bus.served_cnt);
        chk("f3_end_send",   32'(bus.send),        32'h0);
        chk("f3_end_req",    32'(bus.req_laundry), 32'h0);
        chk("f3_end_served", 32'(bus.served_cnt),  32'h2);

        // Short dwell at floor 3
        bus.at_floor = 3'd7;
        step();
        press(4'b1000);
        chk("sd_req", 32'(bus.req_laundry), 32'h8);
        bus.at_floor = 3'd3;
        step();
        chk("sd_settle", 32'(bus.busy), 32'h1);
        bus.at_floor = 3'd5;
        step();
        chk("sd_idle",  32'(bus.busy),       32'h0);
        chk("sd_abort", 32'(bus.load_abort), 32'h0);
        step();
        $display("short dwell: req=%b send=%b abort=%b", bus.req_laundry, bus.send, bus.load_abort);
        chk("sd_abort2", 32'(bus.load_abort),  32'h0);
        chk("sd_send",   32'(bus.send),        32'h0);
        chk("sd_req2",   32'(bus.req_laundry), 32'h8);

        // Abort in the second LOAD cycle of floor 0
        press(4'b0001);
        chk("ab_req", 32'(bus.req_laundry), 32'h9);
        bus.at_floor = 3'd0;
        repeat (3) step();
        chk("ab_load1", 32'(bus.send), 32'h1);
        step();
        chk("ab_load2", 32'(bus.send), 32'h1);
        bus.at_floor = 3'd4;
        step();
        $display("abort: send=%b abort=%b req=%b served=%0d", bus.send, bus.load_abort, bus.req_laundry, bus.served_cnt);
        chk("ab_send",   32'(bus.send),        32'h0);
        chk("ab_pulse",  32'(bus.load_abort),  32'h1);
        chk("ab_req2",   32'(bus.req_laundry), 32'h9);
        chk("ab_served", 32'(bus.served_cnt),  32'h2);
        chk("ab_busy",   32'(bus.busy),        32'h0);
        step();
        chk("ab_pulse_end", 32'(bus.load_abort), 32'h0);

        // Return to floor 0: full load, with an absorbed press during LOAD
        bus.at_floor = 3'd0;
        repeat (3) step();
        chk("rl_send_0", 32'(bus.send), 32'h1);
        bus.btn = 4'b0001;
        step();
        chk("rl_send_1", 32'(bus.send), 32'h1);
        bus.btn = 4'b0000;
        step();
        chk("rl_send_2", 32'(bus.send), 32'h1);
        step();
        chk("rl_send_3", 32'(bus.send), 32'h1);
        step();
        $display("reload f0: req=%b served=%0d", bus.req_laundry, bus.served_cnt);
        chk("rl_end_send",   32'(bus.send),        32'h0);
        chk("rl_end_req",    32'(bus.req_laundry), 32'h8);
        chk("rl_end_served", 32'(bus.served_cnt),  32'h3);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("park_send_%0d", i), 32'(bus.send),        32'h0);
            chk($sformatf("park_req_%0d", i),  32'(bus.req_laundry), 32'h8);
            chk($sformatf("park_busy_%0d", i), 32'(bus.busy),        32'h1);
        end

        // Wrap: 253 more loads on floor 1 bring the total to 256
        bus.at_floor = 3'd7;
        step();
        for (int i = 0; i < 252; i++) do_load(2'd1);
        $display("after 255 loads: served=%0d", bus.served_cnt);
        chk("wrap_255", 32'(bus.served_cnt), 32'hff);
        do_load(2'd1);
        $display("after 256 loads: served=%0d", bus.served_cnt);
        chk("wrap_0", 32'(bus.served_cnt), 32'h0);

        // Reset in the middle of a load
        press(4'b0010);
        bus.at_floor = 3'd1;
        repeat (4) step();
        chk("mr_send", 32'(bus.send),        32'h2);
        chk("mr_req",  32'(bus.req_laundry), 32'ha);
        reset = 1'b0;
        step();
        $display("mid-load reset: send=%b req=%b busy=%b", bus.send, bus.req_laundry, bus.busy);
        chk("mr_send0",  32'(bus.send),        32'h0);
        chk("mr_req0",   32'(bus.req_laundry), 32'h0);
        chk("mr_busy0",  32'(bus.busy),        32'h0);
        chk("mr_abort0", 32'(bus.load_abort),  32'h0);
        reset = 1'b1;
        step();
        chk("mr_after", 32'(bus.send), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/laundry_floor_panel.md
# laundry_floor_panel

Floor-side request/load station for the laundry controller: the block that drives `req_laundry` and `send` into `top` and follows its `at_floor` output. It latches per-floor button presses into pending requests. When the cart dwells at a floor with a pending request, it asserts that floor's `send` line for a fixed loading window, then clears the request. One instance serves all four floors and sits between the floor buttons and the controller.

## Interface
Parameters:
- `DWELL_CYCLES`, default 2: cycles `at_floor` must be stable on a requesting floor before loading starts (≥1).
- `LOAD_CYCLES`, default 4: width of the `send` pulse in cycles (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `btn`  in  4  raw floor buttons, bit f = floor f; asynchronous to `clk`.
- `at_floor`  in  3  cart position from controller. 0–3 = at that floor; 4–7 = in transit or not at a floor.
- `req_laundry`  out  4  pending pickup request per floor.
- `send`  out  4  one-hot (or zero) load strobe to the floor where the cart is.
- `busy`  out  1  high in any state other than IDLE.
- `load_abort`  out  1  one-cycle pulse when a load is cut short.
- `served_cnt`  out  8  count of completed loads; wraps from 255 to 0.

## Operation
- Button path: each `btn` bit passes a 2-flop synchronizer, then a rising-edge detector (third flop). An edge on floor f sets `req_laundry[f]`. Level holds and falling edges have no effect.
- Absorbed presses: if the FSM is in SETTLE, LOAD or RELEASE with latched floor f, an edge on `btn[f]` is ignored. Edges on other floors always set their bits.
- FSM states, with latched floor `fl` (2 bits) and counter `cnt`:
  - IDLE: when `at_floor` < 4 and `req_laundry[at_floor]` = 1, latch `fl` = `at_floor`, set `cnt` = 0, go to SETTLE. Otherwise stay.
  - SETTLE:
    - If `at_floor` ≠ `fl`, go to IDLE. No abort pulse; the request stays pending.
    - Otherwise, when `cnt` = DWELL_CYCLES−1, set `cnt` = 0 and go to LOAD; else increment `cnt`.
  - LOAD:
    - `send[fl]` = 1; all other `send` bits are 0.
    - If `at_floor` ≠ `fl`, pulse `load_abort`, go to IDLE, keep `req_laundry[fl]` set, and drop `send` the next cycle.
    - Otherwise, when `cnt` = LOAD_CYCLES−1, clear `req_laundry[fl]`, increment `served_cnt` and go to RELEASE; else increment `cnt`.
  - RELEASE: wait until `at_floor` ≠ `fl`, then go to IDLE. A cart parked on a floor is never served twice without leaving.
- Only one floor is served at a time. Requests on other floors accumulate untouched.
- Reset has priority over everything, including mid-LOAD. All state and outputs clear and pending requests are discarded.

## Timing
- Reset values: `req_laundry` = 0, `send` = 0, `busy` = 0, `load_abort` = 0, `served_cnt` = 0, state = IDLE. Synchronizer flops clear to 0.
- All outputs are registered except `busy`, which decodes the state register.
- Button latency: `btn[f]` rising before edge k gives `req_laundry[f]` = 1 after edge k+2 (3 cycles).
- Arrival to `send` latency:
  - `at_floor` = f with a pending request, sampled at edge n, moves the FSM to SETTLE at edge n.
  - The FSM enters LOAD at edge n+DWELL_CYCLES.
  - `send[f]` is high for exactly LOAD_CYCLES cycles starting after that edge.
  - `req_laundry[f]` falls on the same edge `send[f]` falls.
- `load_abort` is high for exactly one cycle, aligned with `send` going low.
- `served_cnt` is 8-bit modulo; 255 + 1 = 0.
- `at_floor` 4–7 is never treated as a floor index. It counts as "not equal to `fl`" in SETTLE, LOAD and RELEASE.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles while toggling `btn` → all outputs 0. Release reset, pulse `btn` = 4'b1001 → `req_laundry` = 4'b1001 three cycles later.
- Normal load: `req_laundry` = 4'b1001 with `at_floor` held at 0 → `send` = 4'b0001 for 4 cycles starting 2 cycles after entering SETTLE. Then `req_laundry` = 4'b1000 and `served_cnt` = 1. `at_floor` = 3 → `send` = 4'b1000 for 4 cycles and `served_cnt` = 2.
- Short dwell: `at_floor` = 3 for 1 cycle, then 5 → no `send`, no `load_abort`, `req_laundry[3]` stays 1.
- Abort: `at_floor` changes from 0 to 4 in the 2nd LOAD cycle → `send` drops, `load_abort` pulses once, `req_laundry[0]` stays 1, `served_cnt` unchanged. On return to floor 0, the full load runs again.
- Absorbed and parked: press `btn[0]` during LOAD of floor 0 → request clears at end of load and is not re-set. Keep `at_floor` = 0 → stays in RELEASE with no second `send`.
- Wrap and reset mid-load: complete 256 loads → `served_cnt` = 0. Assert `reset` during LOAD → `send` = 0 and `req_laundry` = 0 on the next edge.
